// File: rtl/cdc_syncfifo.sv
// Single-clock synchronous FIFO with ready/enable handshakes on both sides.
// Define CDC_SYNCFIFO_FWFT_EN for first-word-fall-through reads; default is registered rdata.
module cdc_syncfifo #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              w_en,
  input  logic [DWIDTH-1:0] wdata,
  output logic              wrdy,
  input  logic              r_en,
  output logic              rrdy,
  output logic [DWIDTH-1:0] rdata,
  output logic [AWIDTH:0]   count
);

  localparam int unsigned Depth = 2 ** AWIDTH;

  logic [AWIDTH:0]   wptr_q, wptr_d;
  logic [AWIDTH:0]   rptr_q, rptr_d;
  logic [DWIDTH-1:0] mem_q [Depth];
  logic              empty, full;
  logic              wr_acc, rd_acc;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AWIDTH] != rptr_q[AWIDTH]) &&
            (wptr_q[AWIDTH-1:0] == rptr_q[AWIDTH-1:0]);
  end

  always_comb begin
    wrdy   = !full;
    rrdy   = !empty;
    wr_acc = w_en && !full;
    rd_acc = r_en && !empty;
    count  = wptr_q - rptr_q;
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is intentionally not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q[AWIDTH-1:0]] <= wdata;
  end

`ifdef CDC_SYNCFIFO_FWFT_EN
  assign rdata = mem_q[rptr_q[AWIDTH-1:0]];
`else
  logic [DWIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) rdata_d = mem_q[rptr_q[AWIDTH-1:0]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: tb/tb_cdc_syncfifo.sv
// Randomized and directed bench for cdc_syncfifo against a queue-based reference model.
module tb_cdc_syncfifo;

  localparam int Dw    = 8;
  localparam int Aw    = 4;
  localparam int Depth = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          w_en;
  logic [Dw-1:0] wdata;
  logic          wrdy;
  logic          r_en;
  logic          rrdy;
  logic [Dw-1:0] rdata;
  logic [Aw:0]   count;

  int checks = 0;
  int errors = 0;

  logic [Dw-1:0] model_q[$];
  logic [Dw-1:0] rdata_m;

  always #5 clk = ~clk;

  cdc_syncfifo #(.DWIDTH(Dw), .AWIDTH(Aw)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .w_en  (w_en),
    .wdata (wdata),
    .wrdy  (wrdy),
    .r_en  (r_en),
    .rrdy  (rrdy),
    .rdata (rdata),
    .count (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(model_q.size()));
    chk({tag, ".wrdy"}, 32'(wrdy), 32'(model_q.size() < Depth));
    chk({tag, ".rrdy"}, 32'(rrdy), 32'(model_q.size() > 0));
`ifdef CDC_SYNCFIFO_FWFT_EN
    if (model_q.size() > 0) chk({tag, ".rdata"}, 32'(rdata), 32'(model_q[0]));
`else
    chk({tag, ".rdata"}, 32'(rdata), 32'(rdata_m));
`endif
  endtask

  // One clock with the given request; model acceptance uses occupancy before the edge.
  task automatic step(input string tag, input logic we, input logic re, input logic [Dw-1:0] wd);
    bit acc_w, acc_r;
    w_en  = we;
    r_en  = re;
    wdata = wd;
    acc_w = we && (model_q.size() < Depth);
    acc_r = re && (model_q.size() > 0);
    @(posedge clk);
    if (acc_r) rdata_m = model_q.pop_front();
    if (acc_w) model_q.push_back(wd);
    #1;
    chk_all(tag);
  endtask

  initial begin
    rstn    = 1'b0;
    w_en    = 1'b0;
    r_en    = 1'b0;
    wdata   = '0;
    rdata_m = '0;

    // Reset held with toggling inputs
    for (int i = 0; i < 4; i++) begin
      w_en  = 1'($urandom);
      r_en  = 1'($urandom);
      wdata = 8'($urandom);
      @(posedge clk);
      #1;
      chk_all("reset_hold");
    end
    w_en = 1'b0;
    r_en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) step("post_reset_idle", 1'b0, 1'b0, 8'h00);

    // Fill with 1..17; 17 is dropped
    for (int i = 1; i <= 17; i++) step("fill", 1'b1, 1'b0, 8'(i));
    chk("fill.count16", 32'(count), 32'd16);
    chk("fill.wrdy0", 32'(wrdy), 32'd0);

    // Drain 17 reads; last one ignored
    for (int i = 1; i <= 17; i++) step("drain", 1'b0, 1'b1, 8'h00);
`ifndef CDC_SYNCFIFO_FWFT_EN
    chk("drain.hold16", 32'(rdata), 32'd16);
`endif
    chk("drain.count0", 32'(count), 32'd0);

    // Streaming 1..50 with both enables; pointers wrap several times
    for (int i = 1; i <= 50; i++) begin
      step("stream", 1'b1, 1'b1, 8'(i));
      chk("stream.count_le1", 32'(count <= 1), 32'd1);
    end
    step("stream_tail", 1'b0, 1'b1, 8'h00);

    // Full with simultaneous read and write
    for (int i = 0; i < 16; i++) step("refill", 1'b1, 1'b0, 8'($urandom));
    step("full_rw", 1'b1, 1'b1, 8'd99);
    chk("full_rw.count15", 32'(count), 32'd15);
    step("full_retry", 1'b1, 1'b0, 8'd99);
    for (int i = 0; i < 16; i++) step("drain99", 1'b0, 1'b1, 8'h00);
`ifndef CDC_SYNCFIFO_FWFT_EN
    chk("drain99.last", 32'(rdata), 32'd99);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("random", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           8'($urandom));
    end
    for (int i = 0; i < 18; i++) step("random_drain", 1'b0, 1'b1, 8'h00);

    // Reset mid-stream with 7 words stored
    for (int i = 0; i < 7; i++) step("pre_rst", 1'b1, 1'b0, 8'($urandom));
    chk("pre_rst.count7", 32'(count), 32'd7);
    w_en = 1'b0;
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    model_q.delete();
    rdata_m = '0;
    chk("async_rst.count", 32'(count), 32'd0);
    chk("async_rst.rrdy", 32'(rrdy), 32'd0);
    chk("async_rst.rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step("after_rst_wr", 1'b1, 1'b0, 8'h5A);
    step("after_rst_rd", 1'b0, 1'b1, 8'h00);
    chk("after_rst.rdata5a", 32'(rdata), 32'h5A);
    step("after_rst_idle", 1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdc_syncfifo.md
# cdc_syncfifo

Single-clock synchronous FIFO with ready/enable handshakes on both the write and the read side. Words of DWIDTH bits are buffered in a 2^AWIDTH-entry circular memory. The block sits between a producer and a consumer running on the same clock, and decouples their burst rates.

## Interface
- DWIDTH, 8: data word width in bits.
- AWIDTH, 4: address width; FIFO depth is 2^AWIDTH (16 by default).

- clk  input  1  sole clock; all state changes on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- w_en  input  1  write request.
- wdata  input  DWIDTH  write data, sampled on an accepted write.
- wrdy  output  1  FIFO not full, so a write is accepted this cycle.
- r_en  input  1  read request.
- rrdy  output  1  FIFO not empty, so a read is accepted this cycle.
- rdata  output  DWIDTH  read data.
- count  output  AWIDTH+1  number of stored words, range 0..2^AWIDTH.

## Operation
- Write accepted when w_en && wrdy: wdata is stored at mem[wptr], and wptr increments.
- Read accepted when r_en && rrdy: the head word is delivered on rdata, and rptr increments.
- Pointers:
  - wptr and rptr are AWIDTH+1 bits wide; the low AWIDTH bits address memory.
  - They wrap modulo 2^(AWIDTH+1).
- Status flags:
  - empty = (wptr == rptr).
  - full = MSBs differ and low bits equal.
  - wrdy = !full; rrdy = !empty.
  - Both flags are pure functions of the registered pointers and never depend combinationally on w_en or r_en.
- count = wptr − rptr, computed modulo 2^(AWIDTH+1).
- Write while full: ignored. No pointer change, no memory change, no error flag.
- Read while empty: ignored. rdata holds its value.
- Simultaneous accepted read and write: both happen, and count is unchanged.
  - When full, only the read is accepted because wrdy=0. One slot frees on the next cycle.
  - When empty, only the write is accepted because rrdy=0. The word becomes readable the next cycle.
  - A write is never bypassed to rdata within the same cycle.
- Reset (asynchronous assert, synchronous-safe release):
  - wptr=0, rptr=0, count=0, wrdy=1, rrdy=0, rdata=0.
  - Memory contents are not reset.
  - Assertion mid-operation discards all stored words immediately.

## Timing
- Write-to-readable latency: a write accepted at edge N makes rrdy=1 after edge N. A read can then be accepted at edge N+1.
- wrdy and rrdy update on the edge following the accepted operation that changes them.
- rdata (default build):
  - Registered; loaded with mem[rptr] at the edge that accepts the read.
  - Valid from that edge onward and held until the next accepted read.
- count updates at the same edge as the pointers.

## Configuration
- Macro: CDC_SYNCFIFO_FWFT_EN.
- Undefined (default): registered-output mode, as described above, with one cycle of read latency.
- Defined: first-word-fall-through mode.
  - rdata = mem[rptr] combinationally, valid whenever rrdy=1.
  - An accepted read advances to the next word after the edge.
  - rdata is don't-care when empty; no output register exists.
  - Reset, flags and count behave identically in both modes.

## Test plan
- Reset: hold rstn=0 with toggling inputs -> wrdy=1, rrdy=0, count=0, rdata=0. Deassert, with no enables -> these values stay unchanged.
- Fill: r_en=0, w_en=1, wdata=1..17 on consecutive cycles -> words 1..16 accepted. count=16, wrdy=0 after the 16th edge. Word 17 is dropped.
- Drain: after the fill, r_en=1 for 17 cycles -> rdata sequence 1..16 in order (default: each word appears the edge after its read). rrdy=0 and count=0 after 16 reads; the 17th read is ignored and rdata stays at 16.
- Streaming: w_en=1 and r_en=1 continuously, wdata=1..50 -> every word read out exactly once, in order, with no loss. count stays ≤1 and pointers wrap past 2^(AWIDTH+1) correctly.
- Full with simultaneous read and write: at count=16, w_en=r_en=1, wdata=99 -> read accepted and write rejected, so count=15. Next cycle the write of 99 is accepted and 99 is read out last.
- Reset mid-stream: assert rstn=0 with count=7 -> count=0, rrdy=0 asynchronously. After release, a write of 0x5A followed by a read returns 0x5A.
